dual_edge_detector: RTL and testbench

//   Moore-style dual-edge detector: emits a one-clock pulse on y for every

---
 rtl/dual_edge_detector.sv | 103 ++++++++++
 tb/tb_dual_edge_detector.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/dual_edge_detector.sv
// Dual-edge detector: synchronizes a possibly asynchronous level input and
// emits a one-cycle pulse on y for every change of the synchronized level.
// rise/fall qualify the direction of the change.
// Outputs are decoded from the registered state only (Moore).
`timescale 1ns/100ps

module dual_edge_detector #(
    parameter int SYNC_STAGES = 2   // 0 bypasses the synchronizer
) (
    input  logic clk,
    input  logic rst_n,
    input  logic x,
    output logic y,
    output logic rise,
    output logic fall
);

    // ZERO/ONE track a stable level.
    // RISE/FALL are the single-cycle pulse states.
    typedef enum logic [1:0] {
        ZERO = 2'd0,
        RISE = 2'd1,
        ONE  = 2'd2,
        FALL = 2'd3
    } state_t;

    // state_q is the observable FSM state.
    // Checkers bind to it hierarchically.
    state_t state_q;
    state_t state_d;
    logic   xs;

    generate
        if (SYNC_STAGES == 0) begin : g_bypass
            assign xs = x;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q;

            // Shift chain: stage 0 samples x, the last stage feeds the FSM.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync_q <= '0;
                end else begin
                    sync_q[0] <= x;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        sync_q[i] <= sync_q[i-1];
                    end
                end
            end

            assign xs = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    // State register.
    // Reset lands in ZERO, so a high input after reset release is reported
    // as a rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ZERO;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    // The pulse states jump straight to the opposite pulse, so an input that
    // alternates every cycle keeps y high with no gap.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ZERO:    state_d = xs ? RISE : ZERO;
            RISE:    state_d = xs ? ONE  : FALL;
            ONE:     state_d = xs ? ONE  : FALL;
            FALL:    state_d = xs ? RISE : ZERO;
            default: state_d = ZERO;
        endcase
    end

    // Output decode from state only.
    // rise and fall are mutually exclusive by construction.
    always_comb begin
        y    = 1'b0;
        rise = 1'b0;
        fall = 1'b0;
        case (state_q)
            RISE: begin
                y    = 1'b1;
                rise = 1'b1;
            end
            FALL: begin
                y    = 1'b1;
                fall = 1'b1;
            end
            default: begin
                y    = 1'b0;
                rise = 1'b0;
                fall = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_dual_edge_detector.sv
// Testbench for dual_edge_detector.
// dut2 uses a 2-stage synchronizer; dut0 uses bypass mode (SYNC_STAGES=0).
`timescale 1ns/100ps

module tb_dual_edge_detector;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk = ~clk;

  logic x2, y2, rise2, fall2;
  logic x0, y0, rise0, fall0;

  dual_edge_detector #(.SYNC_STAGES(2)) dut2 (
    .clk  (clk),
    .rst_n(rst_n),
    .x    (x2),
    .y    (y2),
    .rise (rise2),
    .fall (fall2)
  );

  dual_edge_detector #(.SYNC_STAGES(0)) dut0 (
    .clk  (clk),
    .rst_n(rst_n),
    .x    (x0),
    .y    (y0),
    .rise (rise0),
    .fall (fall0)
  );

  // ---------------------------------------------------------------- checking
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got {y,rise,fall}=%b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- vectors
  // One record per clock for dut2.
  // x is applied before the posedge; exp={y,rise,fall} is checked 1ns after it.
  typedef struct {
    logic       x;
    logic [2:0] exp;
  } vec_t;

  vec_t vecs[18];

  // Scoreboard for the fast-input test: history of sampled x values.
  logic exp_q[$];

  initial begin
    int rise_cnt;
    int changes;
    int pulses;
    logic prev_s;
    logic exp_y, exp_r;

    vecs[0]  = '{1'b0, 3'b000};
    vecs[1]  = '{1'b0, 3'b000};
    vecs[2]  = '{1'b1, 3'b000};
    vecs[3]  = '{1'b1, 3'b000};
    vecs[4]  = '{1'b1, 3'b110};
    vecs[5]  = '{1'b1, 3'b000};
    vecs[6]  = '{1'b0, 3'b000};
    vecs[7]  = '{1'b0, 3'b000};
    vecs[8]  = '{1'b0, 3'b101};
    vecs[9]  = '{1'b1, 3'b000};
    vecs[10] = '{1'b0, 3'b000};
    vecs[11] = '{1'b1, 3'b110};
    vecs[12] = '{1'b0, 3'b101};
    vecs[13] = '{1'b0, 3'b110};
    vecs[14] = '{1'b0, 3'b101};
    vecs[15] = '{1'b0, 3'b000};
    vecs[16] = '{1'b0, 3'b000};
    vecs[17] = '{1'b0, 3'b000};

    // 1. Reset hold with toggling inputs.
    x2 = 1'b0;
    x0 = 1'b0;
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      x2 = ~x2;
      x0 = ~x0;
      @(posedge clk);
      #1;
      check("reset_hold_s2", {y2, rise2, fall2}, 3'b000);
      check("reset_hold_s0", {y0, rise0, fall0}, 3'b000);
    end
    @(negedge clk);
    x2 = 1'b0;
    x0 = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_release_s2", {y2, rise2, fall2}, 3'b000);

    // 2/3. Table-driven single rise, single fall and back-to-back edges.
    for (int i = 0; i < 18; i++) begin
      x2 = vecs[i].x;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), {y2, rise2, fall2}, vecs[i].exp);
    end

    // 4. Bypass mode: x toggles every clock, so y stays high and rise/fall alternate.
    for (int i = 0; i < 10; i++) begin
      x0 = ~x0;
      @(posedge clk);
      #1;
      check($sformatf("toggle_s0_%0d", i), {y0, rise0, fall0}, {1'b1, x0, ~x0});
    end
    @(posedge clk);
    #1;
    check("toggle_s0_stop", {y0, rise0, fall0}, 3'b000);

    // Reset asserted mid-pulse: y drops without waiting for a clock edge.
    x2 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("pre_reset_pulse", {y2, rise2, fall2}, 3'b110);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_drop", {y2, rise2, fall2}, 3'b000);

    // 6. x=1 at reset release gives exactly one rise pulse, 3rd clock after release.
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rise_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("x1_release_%0d", i), {y2, rise2, fall2}, (i == 2) ? 3'b110 : 3'b000);
      if (y2) rise_cnt++;
    end
    check_int("x1_release_pulses", rise_cnt, 1);

    // Return to a quiet low level before the asynchronous test.
    x2 = 1'b0;
    repeat (6) @(posedge clk);

    // 5. Fast asynchronous input.
    // Toggles fall at posedge+0.5ns+7k, never on a clock edge, so each
    // posedge sample is well defined.
    exp_q = '{1'b0, 1'b0, 1'b0, 1'b0};
    changes = 0;
    pulses = 0;
    prev_s = 1'b0;
    fork
      begin
        #0.5;
        for (int t = 0; t < 100; t++) begin
          x2 = ~x2;
          #7;
        end
      end
      begin
        for (int c = 0; c < 45; c++) begin
          @(posedge clk);
          exp_q.push_back(x2);
          if (x2 != prev_s) changes++;
          prev_s = x2;
          void'(exp_q.pop_front());
          // Output after this edge reflects the sample from two edges ago
          // compared with the one before it.
          exp_y = exp_q[1] ^ exp_q[0];
          exp_r = exp_y & exp_q[1];
          #1;
          check($sformatf("async_%0d", c), {y2, rise2, fall2}, {exp_y, exp_r, exp_y & ~exp_r});
          if (y2) pulses++;
        end
      end
    join
    check_int("async_pulse_count", pulses, changes);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
